// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Control sequencer for a multi-cycle RISC-V style datapath. Each instruction
//   is walked through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The block emits
//   one-cycle strobes for the PC, the instruction register and the register-file
//   write port. It also emits held read/write requests toward data memory, which
//   are completed by the mem_ready handshake.
//
//   The opcode is classified once, in DECODE, while the IR is guaranteed to hold
//   the instruction. EXEC and MEM then act on that registered class, so the
//   strobes depend only on registered state. The one exception is the store
//   completion strobe, which must appear in the same cycle mem_ready does.
//
//   Optional feature macro: PERF_CNT_EN
//     defined   -> busy-cycle counter (cycle_cnt) and retired-instruction counter
//                  (instr_cnt), both wrapping modulo 2^CNT_W.
//     undefined -> no counter flops; cycle_cnt and instr_cnt are tied to zero.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ir_en,
    output logic             rf_we,
    output logic             dmem_rd,
    output logic             dmem_wr,
    output logic [2:0]       state_out,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_ALU     = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_SYSTEM  = 3'd5
    } op_class_e;

    // The last MEM cycle that may still complete. A miss here means the access has timed out.
    localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [TO_W-1:0] WAIT_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

    // Map a raw opcode onto the handful of sequencing behaviours the FSM cares about.
    function automatic op_class_e classify_op(input logic [6:0] op);
        op_class_e cls;
        case (op)
            7'b0000011: cls = CLS_LOAD;
            7'b0100011: cls = CLS_STORE;
            7'b0110011: cls = CLS_ALU;
            7'b0010011: cls = CLS_ALU;
            7'b0110111: cls = CLS_ALU;
            7'b0010111: cls = CLS_ALU;
            7'b1101111: cls = CLS_ALU;
            7'b1100111: cls = CLS_ALU;
            7'b1100011: cls = CLS_BRANCH;
            7'b1110011: cls = CLS_SYSTEM;
            default:    cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    state_e          state_r;
    state_e          state_nxt_s;
    op_class_e       op_class_r;
    logic [TO_W-1:0] wait_cnt_r;
    logic            err_r;
    logic            err_set_s;
    logic            retire_s;
    logic            busy_s;

    // State register. Reset returns the FSM to IDLE immediately, aborting any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic, plus detection of retire and fault events.
    always_comb begin
        state_nxt_s = state_r;
        retire_s    = 1'b0;
        err_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_nxt_s = ST_DECODE;
            end
            ST_DECODE: begin
                state_nxt_s = ST_EXEC;
            end
            ST_EXEC: begin
                case (op_class_r)
                    CLS_LOAD:   state_nxt_s = ST_MEM;
                    CLS_STORE:  state_nxt_s = ST_MEM;
                    CLS_ALU:    state_nxt_s = ST_WB;
                    CLS_BRANCH: begin
                        retire_s = 1'b1;
                        if (run) begin
                            state_nxt_s = ST_FETCH;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end
                    CLS_SYSTEM: state_nxt_s = ST_HALT;
                    default: begin
                        state_nxt_s = ST_HALT;
                        err_set_s   = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                // A mem_ready on the final permitted cycle still counts as a successful access.
                if (mem_ready) begin
                    case (op_class_r)
                        CLS_LOAD: state_nxt_s = ST_WB;
                        CLS_STORE: begin
                            retire_s = 1'b1;
                            if (run) begin
                                state_nxt_s = ST_FETCH;
                            end else begin
                                state_nxt_s = ST_IDLE;
                            end
                        end
                        default: begin
                            state_nxt_s = ST_HALT;
                            err_set_s   = 1'b1;
                        end
                    endcase
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_nxt_s = ST_HALT;
                    err_set_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_MEM;
                end
            end
            ST_WB: begin
                retire_s = 1'b1;
                if (run) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                // The unused encoding is treated as a fault, so a corrupted state parks safely.
                state_nxt_s = ST_HALT;
                err_set_s   = 1'b1;
            end
        endcase
    end

    // Capture the opcode class in DECODE, the first cycle the IR holds the new instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_class_r <= CLS_ILLEGAL;
        end else if (state_r == ST_DECODE) begin
            op_class_r <= classify_op(opcode);
        end else begin
            op_class_r <= op_class_r;
        end
    end

    // Count cycles spent in MEM. The count clears as soon as MEM is left.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= {TO_W{1'b0}};
        end else if ((state_r == ST_MEM) && (state_nxt_s == ST_MEM)) begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
        end else begin
            wait_cnt_r <= {TO_W{1'b0}};
        end
    end

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Decode the strobes and requests from the registered state and the latched opcode class.
    always_comb begin
        ir_en   = 1'b0;
        rf_we   = 1'b0;
        dmem_rd = 1'b0;
        dmem_wr = 1'b0;
        case (state_r)
            ST_FETCH: ir_en = 1'b1;
            ST_WB:    rf_we = 1'b1;
            ST_MEM: begin
                if (op_class_r == CLS_LOAD) begin
                    dmem_rd = 1'b1;
                end else if (op_class_r == CLS_STORE) begin
                    dmem_wr = 1'b1;
                end else begin
                    dmem_rd = 1'b0;
                    dmem_wr = 1'b0;
                end
            end
            default: begin
                ir_en   = 1'b0;
                rf_we   = 1'b0;
                dmem_rd = 1'b0;
                dmem_wr = 1'b0;
            end
        endcase
    end

    assign busy_s    = (state_r != ST_IDLE) && (state_r != ST_HALT);
    assign pc_en     = retire_s;
    assign state_out = state_r;
    assign busy      = busy_s;
    assign halted    = (state_r == ST_HALT);
    assign err       = err_r;

`ifdef PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cycle_cnt_r;
    logic [CNT_W-1:0] instr_cnt_r;

    // Busy-cycle counter. It holds in IDLE/HALT and wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt_r <= {CNT_W{1'b0}};
        end else if (busy_s) begin
            cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
        end else begin
            cycle_cnt_r <= cycle_cnt_r;
        end
    end

    // Retired-instruction counter. It advances on every retire strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_cnt_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            instr_cnt_r <= instr_cnt_r + CNT_ONE;
        end else begin
            instr_cnt_r <= instr_cnt_r;
        end
    end

    assign cycle_cnt = cycle_cnt_r;
    assign instr_cnt = instr_cnt_r;
`else
    assign cycle_cnt = {CNT_W{1'b0}};
    assign instr_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer
//   Self-checking bench for multicycle_sequencer: directed vector tables, a few
//   hand-written corner sequences and randomized instruction streams. Expected
//   per-cycle outputs come from an instruction-level trace generator that follows
//   the documented latencies and handshake rules.
module tb_multicycle_sequencer;

    localparam int CNT_W = 32;
    localparam int TO    = 15;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_RTYPE = 7'b0110011,
                           OP_ITYPE = 7'b0010011, OP_JAL = 7'b1101111, OP_BRANCH = 7'b1100011,
                           OP_SYSTEM = 7'b1110011, OP_BAD = 7'b1111111;

    typedef struct packed {
        logic        run;
        logic [6:0]  op;
        logic        mr;
        logic [10:0] exp;   // {state, pc_en, ir_en, rf_we, dmem_rd, dmem_wr, busy, halted, err}
    } vec_t;

    logic             clk;
    logic             reset;
    logic             run;
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             pc_en, ir_en, rf_we, dmem_rd, dmem_wr;
    logic [2:0]       state_out;
    logic             busy, halted, err;
    logic [CNT_W-1:0] cycle_cnt, instr_cnt;

    int               n_tests;
    int               n_fail;
    logic [CNT_W-1:0] cyc_m;
    logic [CNT_W-1:0] ins_m;
    logic             err_m;
    bit               in_idle;

    multicycle_sequencer #(.MEM_TIMEOUT(TO), .TO_W(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .pc_en(pc_en), .ir_en(ir_en), .rf_we(rf_we), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
        .state_out(state_out), .busy(busy), .halted(halted), .err(err),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input logic r, input logic [6:0] op, input logic mr,
                               input logic [2:0] st, input logic pc, input logic ir,
                               input logic rf, input logic rd, input logic wr, input logic e);
        vec_t t;
        t.run = r;
        t.op  = op;
        t.mr  = mr;
        t.exp = {st, pc, ir, rf, rd, wr, (st != S_IDLE) && (st != S_HALT), (st == S_HALT), e};
        return t;
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rnd_op();
        return 7'($urandom);
    endfunction

    function automatic bit is_alu(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return is_alu(op) || (op inside {OP_LOAD, OP_STORE, OP_BRANCH, OP_SYSTEM});
    endfunction

    task automatic check_now(input logic [10:0] e, input string nm);
        logic [10:0]      got;
        logic [CNT_W-1:0] ec;
        logic [CNT_W-1:0] ei;
        got = {state_out, pc_en, ir_en, rf_we, dmem_rd, dmem_wr, busy, halted, err};
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s: outputs {st,pc,ir,rf,rd,wr,busy,halt,err} got %b want %b", nm, got, e);
        end
`ifdef PERF_CNT_EN
        ec = cyc_m;
        ei = ins_m;
`else
        ec = '0;
        ei = '0;
`endif
        n_tests++;
        if ((cycle_cnt !== ec) || (instr_cnt !== ei)) begin
            n_fail++;
            $display("FAIL %s_cnt: cycle_cnt got %0d want %0d, instr_cnt got %0d want %0d",
                     nm, cycle_cnt, ec, instr_cnt, ei);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge, check, then move to the next falling edge.
    task automatic apply(input vec_t t, input string nm);
        run       = t.run;
        opcode    = t.op;
        mem_ready = t.mr;
        #1;
        check_now(t.exp, nm);
        if (t.exp[2]) cyc_m = cyc_m + 1;
        if (t.exp[7]) ins_m = ins_m + 1;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        reset     = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b0;
        #1;
        cyc_m   = '0;
        ins_m   = '0;
        err_m   = 1'b0;
        check_now(11'b0, "reset");
        @(negedge clk);
        reset   = 1'b1;
        in_idle = 1'b1;
    endtask

    // Generate and check one instruction from its documented cycle-by-cycle schedule.
    task automatic run_instr(input logic [6:0] op, input int w, input logic run_end, output bit stopped);
        int   k;
        logic ld;
        logic st;
        bit   done;
        ld      = (op == OP_LOAD);
        st      = (op == OP_STORE);
        stopped = 1'b0;
        if (in_idle) begin
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++)
                apply(v(1'b0, rnd_op(), rnd_bit(), S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, err_m), "rnd_idle_hold");
            apply(v(1'b1, rnd_op(), rnd_bit(), S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, err_m), "rnd_idle_go");
        end
        apply(v(rnd_bit(), op, rnd_bit(), S_FETCH, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, err_m), "rnd_fetch");
        apply(v(rnd_bit(), op, rnd_bit(), S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, err_m), "rnd_decode");
        if (op == OP_BRANCH) begin
            apply(v(run_end, op, rnd_bit(), S_EXEC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, err_m), "rnd_branch");
        end else begin
            apply(v(rnd_bit(), op, rnd_bit(), S_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, err_m), "rnd_exec");
            if (is_alu(op)) begin
                apply(v(run_end, op, rnd_bit(), S_WB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, err_m), "rnd_wb");
            end else if (ld || st) begin
                done = 1'b0;
                for (int j = 0; j < TO; j++) begin
                    if (!done) begin
                        if (j == w) begin
                            done = 1'b1;
                            if (st) begin
                                apply(v(run_end, op, 1'b1, S_MEM, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, err_m), "rnd_store_done");
                            end else begin
                                apply(v(rnd_bit(), op, 1'b1, S_MEM, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, err_m), "rnd_load_done");
                                apply(v(run_end, op, rnd_bit(), S_WB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, err_m), "rnd_load_wb");
                            end
                        end else begin
                            apply(v(rnd_bit(), op, 1'b0, S_MEM, 1'b0, 1'b0, 1'b0, ld, st, err_m), "rnd_mem_wait");
                        end
                    end
                end
                if (!done) begin
                    err_m   = 1'b1;
                    stopped = 1'b1;
                end
            end else begin
                if (op != OP_SYSTEM) err_m = 1'b1;
                stopped = 1'b1;
            end
        end
        if (stopped) begin
            for (int j = 0; j < 2; j++)
                apply(v(rnd_bit(), rnd_op(), rnd_bit(), S_HALT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, err_m), "rnd_halt");
        end else begin
            in_idle = !run_end;
        end
    endtask

    initial begin
        vec_t       tbl1[$];
        vec_t       tbl2[$];
        logic [6:0] alu_ops[6];
        logic [6:0] op;
        int         r;
        int         w;
        bit         stopped;
        logic [CNT_W-1:0] exp_c;
        logic [CNT_W-1:0] exp_i;

        alu_ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
        n_tests = 0;
        n_fail  = 0;
        cyc_m   = '0;
        ins_m   = '0;
        err_m   = 1'b0;
        in_idle = 1'b1;

        // Three ALU-class instructions back to back, then drop to IDLE.
        tbl1.push_back(v(1'b1, OP_RTYPE, 1'b0, S_IDLE,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl1.push_back(v(1'b1, OP_RTYPE, 1'b0, S_FETCH,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl1.push_back(v(1'b0, OP_RTYPE, 1'b1, S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl1.push_back(v(1'b1, OP_RTYPE, 1'b0, S_EXEC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl1.push_back(v(1'b1, OP_RTYPE, 1'b0, S_WB,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl1.push_back(v(1'b0, OP_ITYPE, 1'b0, S_FETCH,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl1.push_back(v(1'b0, OP_ITYPE, 1'b0, S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl1.push_back(v(1'b0, OP_ITYPE, 1'b0, S_EXEC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl1.push_back(v(1'b1, OP_ITYPE, 1'b0, S_WB,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl1.push_back(v(1'b1, OP_JAL,   1'b0, S_FETCH,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl1.push_back(v(1'b1, OP_JAL,   1'b0, S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl1.push_back(v(1'b1, OP_JAL,   1'b0, S_EXEC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl1.push_back(v(1'b0, OP_JAL,   1'b0, S_WB,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl1.push_back(v(1'b0, OP_JAL,   1'b1, S_IDLE,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Load with two wait cycles, store with one, branch with run dropped in DECODE, then an illegal opcode.
        tbl2.push_back(v(1'b1, OP_LOAD,   1'b0, S_IDLE,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl2.push_back(v(1'b0, OP_LOAD,   1'b0, S_FETCH,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl2.push_back(v(1'b0, OP_LOAD,   1'b1, S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl2.push_back(v(1'b0, OP_LOAD,   1'b0, S_EXEC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl2.push_back(v(1'b0, OP_LOAD,   1'b0, S_MEM,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        tbl2.push_back(v(1'b1, OP_LOAD,   1'b0, S_MEM,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        tbl2.push_back(v(1'b1, OP_LOAD,   1'b1, S_MEM,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        tbl2.push_back(v(1'b0, OP_LOAD,   1'b0, S_WB,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl2.push_back(v(1'b1, OP_STORE,  1'b0, S_IDLE,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl2.push_back(v(1'b0, OP_STORE,  1'b0, S_FETCH,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl2.push_back(v(1'b0, OP_STORE,  1'b0, S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl2.push_back(v(1'b0, OP_STORE,  1'b1, S_EXEC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl2.push_back(v(1'b0, OP_STORE,  1'b0, S_MEM,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        tbl2.push_back(v(1'b1, OP_STORE,  1'b1, S_MEM,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        tbl2.push_back(v(1'b1, OP_BRANCH, 1'b0, S_FETCH,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl2.push_back(v(1'b0, OP_BRANCH, 1'b0, S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl2.push_back(v(1'b0, OP_BRANCH, 1'b0, S_EXEC,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl2.push_back(v(1'b0, OP_BAD,    1'b0, S_IDLE,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl2.push_back(v(1'b1, OP_BAD,    1'b0, S_IDLE,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl2.push_back(v(1'b1, OP_BAD,    1'b0, S_FETCH,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl2.push_back(v(1'b1, OP_BAD,    1'b0, S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl2.push_back(v(1'b1, OP_BAD,    1'b0, S_EXEC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl2.push_back(v(1'b1, OP_BAD,    1'b1, S_HALT,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        tbl2.push_back(v(1'b0, OP_LOAD,   1'b1, S_HALT,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));

        reset     = 1'b0;
        run       = 1'b0;
        opcode    = 7'b0000000;
        mem_ready = 1'b0;
        @(negedge clk);

        reset_dut();
        for (int i = 0; i < tbl1.size(); i++) apply(tbl1[i], $sformatf("tbl1_%0d", i));

        // Twelve busy cycles and three retirements after the ALU burst.
`ifdef PERF_CNT_EN
        exp_c = 32'd12;
        exp_i = 32'd3;
`else
        exp_c = 32'd0;
        exp_i = 32'd0;
`endif
        run = 1'b0;
        #1;
        n_tests++;
        if ((cycle_cnt !== exp_c) || (instr_cnt !== exp_i)) begin
            n_fail++;
            $display("FAIL perf_burst: cycle_cnt got %0d want %0d, instr_cnt got %0d want %0d",
                     cycle_cnt, exp_c, instr_cnt, exp_i);
        end
        @(negedge clk);

        reset_dut();
        for (int i = 0; i < tbl2.size(); i++) apply(tbl2[i], $sformatf("tbl2_%0d", i));

        // Store that never completes: fifteen MEM cycles, then a fault halt.
        reset_dut();
        apply(v(1'b1, OP_STORE, 1'b0, S_IDLE,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "to_idle");
        apply(v(1'b1, OP_STORE, 1'b0, S_FETCH,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "to_fetch");
        apply(v(1'b1, OP_STORE, 1'b0, S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "to_decode");
        apply(v(1'b1, OP_STORE, 1'b0, S_EXEC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "to_exec");
        for (int j = 0; j < TO; j++)
            apply(v(1'b1, OP_STORE, 1'b0, S_MEM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), $sformatf("to_mem_%0d", j));
        apply(v(1'b1, OP_STORE, 1'b1, S_HALT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "to_halt");
        apply(v(1'b1, OP_STORE, 1'b1, S_HALT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "to_halt_hold");

        // Reset asserted in the middle of EXEC takes effect before the next clock edge.
        reset_dut();
        apply(v(1'b1, OP_RTYPE, 1'b0, S_IDLE,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "ar_idle");
        apply(v(1'b1, OP_RTYPE, 1'b0, S_FETCH,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "ar_fetch");
        apply(v(1'b1, OP_RTYPE, 1'b0, S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "ar_decode");
        run       = 1'b1;
        opcode    = OP_RTYPE;
        mem_ready = 1'b0;
        #1;
        check_now({S_EXEC, 8'b0000_0100}, "ar_exec");
        #1;
        reset = 1'b0;
        #1;
        cyc_m = '0;
        ins_m = '0;
        check_now(11'b0, "ar_async");
        @(negedge clk);
        reset   = 1'b1;
        in_idle = 1'b1;
        apply(v(1'b0, OP_RTYPE, 1'b0, S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "ar_after");

        // Randomized instruction streams against the schedule model.
        reset_dut();
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            w = 0;
            if (r < 30)      op = alu_ops[$urandom_range(0, 5)];
            else if (r < 45) op = OP_BRANCH;
            else if (r < 62) op = OP_LOAD;
            else if (r < 79) op = OP_STORE;
            else if (r < 83) op = OP_SYSTEM;
            else if (r < 87) begin
                op = rnd_op();
                while (is_legal(op)) op = rnd_op();
            end else         op = alu_ops[$urandom_range(0, 5)];
            if ((op == OP_LOAD) || (op == OP_STORE)) begin
                if ($urandom_range(0, 9) < 7) w = $urandom_range(0, 3);
                else                          w = $urandom_range(12, 16);
            end
            run_instr(op, w, ($urandom_range(0, 3) != 0), stopped);
            if (stopped) reset_dut();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
